// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory port controller: FSM states, access size codes
// and the address window check.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    // Modulo-2^32 subtraction makes addresses below the base wrap to huge offsets.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth_words);
        logic [31:0] off;
        off = addr - base;
        return (off >> 2) < depth_words;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store replication / byte enables and load lane extraction with extension.
// Purely combinational, zero latency, no backpressure.
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sign,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [15:0] sh;

    always_comb begin
        be       = 4'b0000;
        st_lanes = st_data;
        ld_data  = 32'h0;
        // lo is already aligned for halves/words, so one shift serves every size
        sh       = 16'(ld_word >> {lo, 3'b000});
        case (size)
            SZ_B: begin
                be       = 4'b0001 << lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {{24{sign & sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                be       = 4'b0011 << {lo[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {{16{sign & sh[15]}}, sh[15:0]};
            end
            SZ_W: begin
                be       = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Core-to-DMEM port controller; store 2 stall cycles, load 1+RD_LAT, fault 1; stalls core via cpu_stall.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults instead of force-aligning.
module dmem_port_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 1
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic                           cpu_req,
    input  logic                           cpu_we,
    input  logic [1:0]                     cpu_size,
    input  logic                           cpu_sign,
    input  logic [31:0]                    cpu_addr,
    input  logic [31:0]                    cpu_wdata,
    output logic [31:0]                    cpu_rdata,
    output logic                           cpu_stall,
    output logic                           cpu_fault,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [3:0]                     mem_be,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic [31:0]                    mem_wdata,
    input  logic [31:0]                    mem_rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

    state_t      state;
    logic [1:0]  cnt;
    logic        req_we;
    logic [1:0]  req_size;
    logic [1:0]  req_lo;
    logic        req_sign;

    logic [AW-1:0] word_idx;
    logic [1:0]    eff_lo;
    logic          misalign;
    logic          req_fault;
    logic [1:0]    al_size;
    logic [1:0]    al_lo;
    logic          al_sign;
    logic [3:0]    al_be;
    logic [31:0]   al_st;
    logic [31:0]   al_ld;

    assign cpu_stall = cpu_req && (state != DONE);
    assign word_idx  = AW'((cpu_addr - BASE_ADDR) >> 2);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((cpu_size == SZ_H) && cpu_addr[0]) ||
                      ((cpu_size == SZ_W) && (cpu_addr[1:0] != 2'b00));
    assign eff_lo   = cpu_addr[1:0];
`else
    assign misalign = 1'b0;
    always_comb begin
        case (cpu_size)
            SZ_H:    eff_lo = {cpu_addr[1], 1'b0};
            SZ_W:    eff_lo = 2'b00;
            default: eff_lo = cpu_addr[1:0];
        endcase
    end
`endif

    assign req_fault = !addr_in_range(cpu_addr, BASE_ADDR, 32'(DEPTH_WORDS)) ||
                       (cpu_size == SZ_RSV) || misalign;

    // Live inputs steer lanes when issuing; the latched copy serves the load return.
    assign al_size = (state == IDLE) ? cpu_size : req_size;
    assign al_lo   = (state == IDLE) ? eff_lo   : req_lo;
    assign al_sign = (state == IDLE) ? cpu_sign : req_sign;

    dmem_lane_align u_lane (
        .size     (al_size),
        .lo       (al_lo),
        .sign     (al_sign),
        .st_data  (cpu_wdata),
        .ld_word  (mem_rdata),
        .be       (al_be),
        .st_lanes (al_st),
        .ld_data  (al_ld)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            req_we    <= 1'b0;
            req_size  <= SZ_B;
            req_lo    <= 2'b00;
            req_sign  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            cpu_rdata <= 32'h0;
            cpu_fault <= 1'b0;
        end else begin
            // Memory strobes live for exactly the ISSUE cycle.
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we   <= cpu_we;
                        req_size <= cpu_size;
                        req_lo   <= eff_lo;
                        req_sign <= cpu_sign;
                        if (req_fault) begin
                            state     <= DONE;
                            cpu_fault <= 1'b1;
                            cpu_rdata <= 32'h0;
                        end else begin
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_be    <= al_be;
                            mem_addr  <= word_idx;
                            mem_wdata <= al_st;
                        end
                    end
                end
                ISSUE: begin
                    if (req_we) begin
                        state <= DONE;
                    end else if (RD_LAT > 1) begin
                        state <= WAIT;
                        cnt   <= 2'd0;
                    end else begin
                        state     <= DONE;
                        cpu_rdata <= al_ld;
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state     <= DONE;
                        cpu_rdata <= al_ld;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cpu_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Randomized bench for dmem_port_ctrl against a byte-array reference of DMEM contents.
// Drives on the falling edge, samples 1 time unit later.
module tb_dmem_port_ctrl;

    localparam logic [31:0] BASE   = 32'h10010000;
    localparam int          DEPTH  = 256;
    localparam int          RD_LAT = 3;
    localparam int          AW     = $clog2(DEPTH);

    logic          clk_in = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_sign;
    logic [1:0]    cpu_size;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall, cpu_fault;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    dmem_port_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_size  (cpu_size),
        .cpu_sign  (cpu_sign),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_fault (cpu_fault),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Fixed-latency memory: data for the address strobed in ISSUE is present RD_LAT edges later.
    logic [31:0] mem_arr [DEPTH];
    logic [31:0] rd0;
    logic [31:0] dl [1:4];
    assign rd0       = mem_arr[mem_addr];
    assign mem_rdata = (RD_LAT == 1) ? rd0 : dl[RD_LAT-1];

    always @(posedge clk_in) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        dl[1] <= rd0;
        for (int k = 2; k <= 4; k++) dl[k] <= dl[k-1];
    end

    // Reference view of DMEM as plain bytes.
    logic [7:0] ref_mem [DEPTH*4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_fault(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] off;
        logic f;
        off = addr - BASE;
        f = (off / 4 >= DEPTH) || (size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [31:0] aligned(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd1) return addr & ~32'd1;
        if (size == 2'd2) return addr & ~32'd3;
        return addr;
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic        f, done;
        logic [31:0] ea, idx, exp_rd, exp_wd;
        int          n, stalls, en_cnt;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        logic        s_we;
        f      = exp_fault(addr, size);
        ea     = aligned(addr, size);
        idx    = ea - BASE;
        n      = nbytes(size);
        exp_rd = 32'h0;
        exp_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        if (!f && !we) begin
            for (int k = 0; k < n; k++) exp_rd |= 32'(ref_mem[idx + 32'(k)]) << (8 * k);
            if (sgn && n < 4 && exp_rd[8*n-1]) exp_rd |= ~((32'd1 << (8 * n)) - 32'd1);
        end
        cpu_we = we; cpu_size = size; cpu_sign = sgn; cpu_addr = addr; cpu_wdata = wd;
        cpu_req = 1'b1;
        stalls = 0; en_cnt = 0; done = 1'b0;
        s_addr = 0; s_wdata = 0; s_be = 0; s_we = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (cpu_stall) begin
                stalls++;
                if (mem_en) begin
                    en_cnt++;
                    s_addr = 32'(mem_addr); s_be = mem_be; s_we = mem_we; s_wdata = mem_wdata;
                end
                @(negedge clk_in);
            end else begin
                done = 1'b1;
            end
        end
        check("done", 32'(done), 32'd1);
        check("stalls", stalls, f ? 1 : we ? 2 : 1 + RD_LAT);
        check("en_cnt", en_cnt, f ? 0 : 1);
        check("fault", 32'(cpu_fault), 32'(f));
        check("en_done", 32'(mem_en), 32'd0);
        if (!f) begin
            check("mem_addr", s_addr, idx >> 2);
            check("mem_we", 32'(s_we), 32'(we));
        end
        if (!f && we) begin
            check("mem_be", 32'(s_be), ((32'd1 << n) - 32'd1) << (ea % 4));
            check("mem_wdata", s_wdata, exp_wd);
            for (int k = 0; k < n; k++) ref_mem[idx + 32'(k)] = wd[8*k +: 8];
        end
        if (!we || f) check("rdata", cpu_rdata, exp_rd);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        logic [31:0] rd, a, w;
        logic [1:0]  sz;

        for (int i = 0; i < DEPTH; i++) begin
            mem_arr[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = mem_arr[i][8*b +: 8];
        end
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_sign = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_fault", 32'(cpu_fault), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);

        access(1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'hDEADBEEF, rd);
        access(1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'h0, rd);
        check("reload_word", rd, 32'hDEADBEEF);

        access(1'b1, 2'd0, 1'b0, BASE + 32'h3, 32'h00000080, rd);
        access(1'b0, 2'd0, 1'b1, BASE + 32'h3, 32'h0, rd);
        check("ld_sbyte", rd, 32'hFFFFFF80);
        access(1'b0, 2'd0, 1'b0, BASE + 32'h3, 32'h0, rd);
        check("ld_ubyte", rd, 32'h00000080);

        access(1'b0, 2'd0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, rd);
        access(1'b0, 2'd2, 1'b0, 32'h1000FFFC, 32'h0, rd);
        access(1'b1, 2'd3, 1'b0, BASE + 32'h10, 32'h12345678, rd);

        access(1'b0, 2'd1, 1'b1, BASE + 32'h1, 32'h0, rd);

        // Reset while the load is waiting on memory.
        access(1'b1, 2'd2, 1'b0, BASE + 32'h20, 32'hA5A5_5A5A, rd);
        access(1'b0, 2'd2, 1'b0, BASE + 32'h20, 32'h0, rd);
        cpu_we = 1'b0; cpu_size = 2'd2; cpu_sign = 1'b0; cpu_addr = BASE + 32'h24; cpu_req = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        check("wrst_rdata", cpu_rdata, 0);
        check("wrst_mem_en", 32'(mem_en), 0);
        check("wrst_stall", 32'(cpu_stall), 0);
        @(negedge clk_in);
        access(1'b0, 2'd2, 1'b0, BASE + 32'h20, 32'h0, rd);

        // Request withdrawn during ISSUE: stall drops at once, store still lands.
        w = $urandom;
        cpu_we = 1'b1; cpu_size = 2'd2; cpu_addr = BASE + 32'h40; cpu_wdata = w; cpu_req = 1'b1;
        @(negedge clk_in);
        cpu_req = 1'b0;
        #1;
        check("drop_stall", 32'(cpu_stall), 0);
        check("drop_mem_en", 32'(mem_en), 1);
        for (int k = 0; k < 4; k++) ref_mem[32'h40 + k] = w[8*k +: 8];
        repeat (2) @(negedge clk_in);
        access(1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0, rd);

        for (int i = 0; i < 300; i++) begin
            case ($urandom % 16)
                0:       a = BASE + 32'(4 * DEPTH) + ($urandom % 64);
                1:       a = BASE - 32'd1 - ($urandom % 64);
                default: a = BASE + ($urandom % (4 * DEPTH));
            endcase
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            access(1'($urandom), sz, 1'($urandom), a, $urandom, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_ctrl.md
# dmem_port_ctrl

Multi-cycle data-memory port controller between the CPU31 core and a synchronous, fixed-latency DMEM. It replaces the single-cycle `(addr - base) / 4` address translation with a parametrised window, and adds byte/halfword lane steering, sign extension, range and alignment checking, and a stall handshake for memories with read latency above one cycle. It sits at top level, with the core's data port on one side and the DMEM array on the other.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h10010000: byte address of DMEM word 0.
- `DEPTH_WORDS`, default 1024: DMEM depth in 32-bit words; must be a power of two.
- `RD_LAT`, default 1: cycles from `mem_en` to valid `mem_rdata`; legal range 1..4.

Ports (clock and reset first):
- `clk_in`, in, 1: the single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `cpu_req`, in, 1: access request; held stable with all `cpu_*` inputs while `cpu_stall`=1.
- `cpu_we`, in, 1: 1 = store, 0 = load.
- `cpu_size`, in, 2: 00 byte, 01 half, 10 word, 11 reserved.
- `cpu_sign`, in, 1: load sign-extends when 1, zero-extends when 0.
- `cpu_addr`, in, 32: byte address.
- `cpu_wdata`, in, 32: store data, right-aligned.
- `cpu_rdata`, out, 32: load result; valid in DONE.
- `cpu_stall`, out, 1: freeze PC and register writes.
- `cpu_fault`, out, 1: access error; valid in DONE.
- `mem_en`, out, 1: memory strobe.
- `mem_we`, out, 1: memory write.
- `mem_be`, out, 4: byte enables, bit i = bits [8i+7:8i].
- `mem_addr`, out, clog2(DEPTH_WORDS): word index.
- `mem_wdata`, out, 32: lane-replicated store data.
- `mem_rdata`, in, 32: memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE with `cpu_req`=0: stay in IDLE.
- IDLE with `cpu_req`=1 and the access legal: go to ISSUE. If it faults: go to DONE.
- ISSUE: store goes to DONE. Load goes to WAIT if RD_LAT>1, otherwise to DONE.
- WAIT: counter counts RD_LAT-1 cycles, then goes to DONE.
- DONE: always returns to IDLE.
- `cpu_stall` = `cpu_req` && state≠DONE (combinational).
- Word offset = (`cpu_addr` - `BASE_ADDR`) >> 2, computed modulo 2^32.
- Out of range (offset ≥ `DEPTH_WORDS`, including wrap below base): fault.
- `cpu_size`=11: fault.
- Faulting access: memory never strobed; `cpu_rdata`=0.
- Store lanes: byte data replicated ×4, `mem_be`=0001<<addr[1:0]. Half data replicated ×2, `mem_be`=0011<<{addr[1],0}. Word: `mem_be`=1111.
- Load: lane selected by the same offsets, then sign- or zero-extended to 32 bits.
- Memory-side outputs are registered. They are valid only in the ISSUE cycle; `mem_en`=0 in every other state.

## Timing
- Reset values: state IDLE; `mem_en`, `mem_we` 0; `mem_be` 0000; `mem_addr`, `mem_wdata` 0; `cpu_rdata` 0; `cpu_fault` 0.
- Store: stalls 2 cycles (IDLE, ISSUE). CPU completes the store at the DONE edge.
- Load: stalls 1+RD_LAT cycles. `mem_rdata` is captured into `cpu_rdata` at the edge RD_LAT cycles after the ISSUE edge.
- Faulted access: stalls 1 cycle.
- Back-to-back requests: the next request is sampled in the IDLE cycle following DONE. There is one dead cycle between requests by design.
- `cpu_req` dropping mid-access: the access still completes, and `cpu_stall` drops immediately.
- Reset asserted in any state: next state is IDLE. An ISSUE-cycle write present at the reset edge may commit; nothing after it does.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- Defined: half with addr[0]=1, or word with addr[1:0]≠00, is a fault.
- Undefined: misaligned addresses are force-aligned by clearing the offending low bits, with no fault.
- Out-of-range and reserved-size faults apply in both builds.

## Structure
- Package `dmem_ctrl_pkg` holds:
  - the state enum;
  - size codes `SZ_B`, `SZ_H`, `SZ_W`, `SZ_RSV`;
  - a function computing the range check.
- Sub-module `dmem_lane_align` (combinational) holds:
  - store replication and `mem_be` generation;
  - load extraction and extension.
- The top-level FSM, counter and registers stay in `dmem_port_ctrl`.

## Test plan
- Store word 32'hDEADBEEF to 32'h10010008: ISSUE shows `mem_addr`=2, `mem_be`=1111, `mem_we`=1, with 2 stall cycles. A reload returns 32'hDEADBEEF.
- Store byte 8'h80 to 32'h10010003, then signed load byte: `mem_be`=1000, `mem_wdata`=32'h80808080, `cpu_rdata`=32'hFFFFFF80. Unsigned load: `cpu_rdata`=32'h00000080.
- RD_LAT=3, load word: `cpu_stall` high exactly 4 cycles, then data valid in DONE.
- Load from 32'h10010000+4*DEPTH_WORDS and from 32'h1000FFFC: `cpu_fault`=1, `mem_en` never high, 1 stall cycle.
- Load half at 32'h10010001: with `DMEM_MISALIGN_TRAP_EN` defined, fault. Without it, reads lanes 1:0 of word 0 with no fault.
- `reset` pulsed during WAIT: next cycle IDLE, `cpu_rdata`=0, `mem_en`=0. A fresh request then completes normally.
